// File: rtl/multi_channel_pit.sv
// multi_channel_pit: 8254-style interval timer, up to three 16-bit channels
// supporting modes 0, 2 and 3, per-channel gates, counter latch, read-back
// and LSB/MSB/word access.
//
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   pit_clk               asynchronous counting clock (synchronised, edge -> tick)
//   gate[NUM_CHANNELS]    per-channel gate, asynchronous
//   cs, data_m_*          16-bit data bus slave; word 0 = {ch1, ch0},
//                         word 1 = {control, ch2}; ack one cycle after access
//   out[NUM_CHANNELS]     channel outputs
//   intr                  copy of out[0] (system tick interrupt)
module multi_channel_pit #(
  parameter int unsigned NUM_CHANNELS = 3,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    pit_clk,
  input  logic [NUM_CHANNELS-1:0] gate,
  input  logic                    cs,
  input  logic [2:1]              data_m_addr,
  input  logic [15:0]             data_m_data_in,
  output logic [15:0]             data_m_data_out,
  input  logic [1:0]              data_m_bytesel,
  input  logic                    data_m_wr_en,
  input  logic                    data_m_access,
  output logic                    data_m_ack,
  output logic [NUM_CHANNELS-1:0] out,
  output logic                    intr
);

  typedef enum logic [1:0] {
    CH_IDLE,   // no count loaded since programming
    CH_ARMED,  // final count byte written, loads on next tick
    CH_RUN
  } ch_state_e;

  // ---------------- synchronisers ----------------
  logic [SYNC_STAGES-1:0]  pclk_sync_q, pclk_sync_d;
  logic                    pclk_prev_q, pclk_prev_d;
  logic [NUM_CHANNELS-1:0] gate_sync_q [SYNC_STAGES];
  logic [NUM_CHANNELS-1:0] gate_sync_d [SYNC_STAGES];
  logic [NUM_CHANNELS-1:0] gate_prev_q, gate_prev_d;
  logic [NUM_CHANNELS-1:0] gate_s, gate_rise;
  logic                    tick;

  always_comb begin
    pclk_sync_d    = {pclk_sync_q[SYNC_STAGES-2:0], pit_clk};
    pclk_prev_d    = pclk_sync_q[SYNC_STAGES-1];
    gate_sync_d[0] = gate;
    for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
      gate_sync_d[s] = gate_sync_q[s-1];
    end
    gate_prev_d = gate_sync_q[SYNC_STAGES-1];
  end

  assign tick      = pclk_sync_q[SYNC_STAGES-1] & ~pclk_prev_q;
  assign gate_s    = gate_sync_q[SYNC_STAGES-1];
  assign gate_rise = gate_s & ~gate_prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pclk_sync_q <= '0;
      pclk_prev_q <= 1'b0;
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        gate_sync_q[s] <= '0;
      end
      gate_prev_q <= '0;
    end else begin
      pclk_sync_q <= pclk_sync_d;
      pclk_prev_q <= pclk_prev_d;
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        gate_sync_q[s] <= gate_sync_d[s];
      end
      gate_prev_q <= gate_prev_d;
    end
  end

  // ---------------- bus decode ----------------
  logic       access, wr_acc, rd_acc, ctrl_sel, ctrl_wr;
  logic [2:0] ch_sel;
  logic [7:0] ctrl;
  logic [7:0] ch_rbyte [3];
  logic [2:0] out_all;
  logic       ack_q, ack_d;
  logic [15:0] rdata_q, rdata_d;

  assign access = cs & data_m_access;
  assign wr_acc = access & data_m_wr_en;
  assign rd_acc = access & ~data_m_wr_en;
  assign ctrl   = data_m_data_in[15:8];

  always_comb begin
    ch_sel   = '0;
    ctrl_sel = 1'b0;
    if (data_m_addr == 2'd0) begin
      ch_sel[0] = data_m_bytesel[0];
      ch_sel[1] = data_m_bytesel[1];
    end else if (data_m_addr == 2'd1) begin
      ch_sel[2] = data_m_bytesel[0];
      ctrl_sel  = data_m_bytesel[1];
    end
  end

  assign ctrl_wr = wr_acc & ctrl_sel;

  // ---------------- channels ----------------
  for (genvar g = 0; g < 3; g++) begin : g_ch
    if (g < NUM_CHANNELS) begin : g_impl
      localparam int unsigned LANE = (g == 1) ? 1 : 0;

      ch_state_e   state_q, state_d;
      logic [2:0]  mode_q, mode_d;
      logic [1:0]  rw_q, rw_d;
      logic        bcd_q, bcd_d;
      logic [15:0] count_q, count_d;
      logic [15:0] reload_q, reload_d;
      logic [15:0] cnt_latch_q, cnt_latch_d;
      logic        cnt_full_q, cnt_full_d;
      logic [7:0]  st_latch_q, st_latch_d;
      logic        st_full_q, st_full_d;
      logic        out_q, out_d;
      logic        null_q, null_d;
      logic        wr_ff_q, wr_ff_d;
      logic        rd_ff_q, rd_ff_d;
      logic [7:0]  lsb_hold_q, lsb_hold_d;
      logic        ext_q, ext_d;    // odd mode-3 extra high tick taken
      logic        pend_q, pend_d;  // gate rising edge, reload on next tick

      logic        sel, prog, latch_cmd, rb_cnt, rb_st, m2, m3;
      logic        fin_byte, first_byte, done_rd;
      logic [15:0] load_val, src;
      logic [7:0]  wbyte, rbyte;

      assign sel       = ch_sel[g];
      assign wbyte     = data_m_data_in[LANE*8 +: 8];
      assign prog      = ctrl_wr && (ctrl[7:6] == 2'(g)) && (ctrl[5:4] != 2'b00);
      assign latch_cmd = ctrl_wr && (ctrl[7:6] == 2'(g)) && (ctrl[5:4] == 2'b00);
      assign rb_cnt    = ctrl_wr && (ctrl[7:6] == 2'b11) && ctrl[g+1] && !ctrl[5];
      assign rb_st     = ctrl_wr && (ctrl[7:6] == 2'b11) && ctrl[g+1] && !ctrl[4];
      // modes x10 / x11 are 2 / 3, everything else counts as mode 0
      assign m2        = mode_q[1] & ~mode_q[0];
      assign m3        = mode_q[1] & mode_q[0];
      assign load_val  = m3 ? {reload_q[15:1], 1'b0} : reload_q;

      always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        rw_d        = rw_q;
        bcd_d       = bcd_q;
        count_d     = count_q;
        reload_d    = reload_q;
        cnt_latch_d = cnt_latch_q;
        cnt_full_d  = cnt_full_q;
        st_latch_d  = st_latch_q;
        st_full_d   = st_full_q;
        out_d       = out_q;
        null_d      = null_q;
        wr_ff_d     = wr_ff_q;
        rd_ff_d     = rd_ff_q;
        lsb_hold_d  = lsb_hold_q;
        ext_d       = ext_q;
        pend_d      = pend_q;
        fin_byte    = 1'b0;
        first_byte  = 1'b0;
        done_rd     = 1'b0;
        src         = cnt_full_q ? cnt_latch_q : count_q;
        rbyte       = '0;

        if (m2 || m3) begin
          if (!gate_s[g])   out_d  = 1'b1;
          if (gate_rise[g]) pend_d = 1'b1;
        end

        // Tick is evaluated first on the old state; a data write in the same
        // cycle then overrides, while a control write suppresses the tick.
        if (tick && !prog) begin
          if (state_q == CH_ARMED) begin
            count_d = load_val;
            null_d  = 1'b0;
            state_d = CH_RUN;
            ext_d   = 1'b0;
            pend_d  = 1'b0;
            if (m2 || m3) out_d = 1'b1;
          end else if (state_q == CH_RUN && gate_s[g]) begin
            if (pend_q && (m2 || m3)) begin
              count_d = load_val;
              out_d   = 1'b1;
              ext_d   = 1'b0;
              pend_d  = 1'b0;
            end else if (m3) begin
              if (count_q == 16'd2) begin
                if (out_q && reload_q[0] && !ext_q) begin
                  ext_d = 1'b1;  // odd N: hold one extra tick while high
                end else begin
                  out_d   = ~out_q;
                  count_d = load_val;
                  ext_d   = 1'b0;
                end
              end else begin
                count_d = count_q - 16'd2;
              end
            end else if (m2) begin
              if (count_q == 16'd1) begin
                count_d = load_val;
                out_d   = 1'b1;
              end else begin
                count_d = count_q - 16'd1;
                if (count_q == 16'd2) out_d = 1'b0;
              end
            end else begin
              count_d = count_q - 16'd1;
              if (count_q == 16'd1) out_d = 1'b1;
            end
          end
        end

        if ((latch_cmd || rb_cnt) && !cnt_full_q) begin
          cnt_latch_d = count_q;
          cnt_full_d  = 1'b1;
        end
        if (rb_st && !st_full_q) begin
          st_latch_d = {out_q, null_q, rw_q, mode_q, bcd_q};
          st_full_d  = 1'b1;
        end

        if (prog) begin
          rw_d    = ctrl[5:4];
          mode_d  = ctrl[3:1];
          bcd_d   = ctrl[0];
          null_d  = 1'b1;
          wr_ff_d = 1'b0;
          rd_ff_d = 1'b0;
          state_d = CH_IDLE;
          out_d   = ctrl[2];
          ext_d   = 1'b0;
          pend_d  = 1'b0;
        end

        if (sel && wr_acc && !prog) begin
          case (rw_q)
            2'b01: begin
              reload_d   = {8'h00, wbyte};
              fin_byte   = 1'b1;
              first_byte = 1'b1;
            end
            2'b10: begin
              reload_d   = {wbyte, 8'h00};
              fin_byte   = 1'b1;
              first_byte = 1'b1;
            end
            2'b11: begin
              if (!wr_ff_q) begin
                lsb_hold_d = wbyte;
                wr_ff_d    = 1'b1;
                first_byte = 1'b1;
              end else begin
                reload_d = {wbyte, lsb_hold_q};
                wr_ff_d  = 1'b0;
                fin_byte = 1'b1;
              end
            end
            default: ;
          endcase
          if (first_byte && !(m2 || m3)) out_d = 1'b0;
          if (fin_byte) begin
            null_d  = 1'b1;
            state_d = CH_ARMED;
          end
        end

        if (sel && rd_acc) begin
          if (st_full_q) begin
            rbyte     = st_latch_q;
            st_full_d = 1'b0;
          end else begin
            case (rw_q)
              2'b10: begin
                rbyte   = src[15:8];
                done_rd = 1'b1;
              end
              2'b11: begin
                rbyte   = rd_ff_q ? src[15:8] : src[7:0];
                rd_ff_d = ~rd_ff_q;
                done_rd = rd_ff_q;
              end
              default: begin
                rbyte   = src[7:0];
                done_rd = 1'b1;
              end
            endcase
            if (cnt_full_q && done_rd) cnt_full_d = 1'b0;
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          state_q     <= CH_IDLE;
          mode_q      <= '0;
          rw_q        <= '0;
          bcd_q       <= 1'b0;
          count_q     <= '0;
          reload_q    <= '0;
          cnt_latch_q <= '0;
          cnt_full_q  <= 1'b0;
          st_latch_q  <= '0;
          st_full_q   <= 1'b0;
          out_q       <= 1'b0;
          null_q      <= 1'b1;
          wr_ff_q     <= 1'b0;
          rd_ff_q     <= 1'b0;
          lsb_hold_q  <= '0;
          ext_q       <= 1'b0;
          pend_q      <= 1'b0;
        end else begin
          state_q     <= state_d;
          mode_q      <= mode_d;
          rw_q        <= rw_d;
          bcd_q       <= bcd_d;
          count_q     <= count_d;
          reload_q    <= reload_d;
          cnt_latch_q <= cnt_latch_d;
          cnt_full_q  <= cnt_full_d;
          st_latch_q  <= st_latch_d;
          st_full_q   <= st_full_d;
          out_q       <= out_d;
          null_q      <= null_d;
          wr_ff_q     <= wr_ff_d;
          rd_ff_q     <= rd_ff_d;
          lsb_hold_q  <= lsb_hold_d;
          ext_q       <= ext_d;
          pend_q      <= pend_d;
        end
      end

      assign ch_rbyte[g] = rbyte;
      assign out_all[g]  = out_q;
    end else begin : g_none
      assign ch_rbyte[g] = '0;
      assign out_all[g]  = 1'b0;
    end
  end

  // ---------------- bus response ----------------
  // Channel read bytes are zero unless selected, so lanes can be OR-merged.
  always_comb begin
    ack_d   = access;
    rdata_d = {ch_rbyte[1], ch_rbyte[0]} | {8'h00, ch_rbyte[2]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  assign data_m_ack      = ack_q;
  assign data_m_data_out = rdata_q;
  assign out             = out_all[NUM_CHANNELS-1:0];
  assign intr            = out_all[0];

endmodule

// File: tb/tb_multi_channel_pit.sv
module tb_multi_channel_pit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pit_clk;
  logic [2:0]  gate;
  logic        cs;
  logic [2:1]  data_m_addr;
  logic [15:0] data_m_data_in;
  logic [15:0] data_m_data_out;
  logic [1:0]  data_m_bytesel;
  logic        data_m_wr_en;
  logic        data_m_access;
  logic        data_m_ack;
  logic [2:0]  out;
  logic        intr;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [15:0] exp_q [$];

  multi_channel_pit #(.NUM_CHANNELS(3), .SYNC_STAGES(2)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .pit_clk         (pit_clk),
    .gate            (gate),
    .cs              (cs),
    .data_m_addr     (data_m_addr),
    .data_m_data_in  (data_m_data_in),
    .data_m_data_out (data_m_data_out),
    .data_m_bytesel  (data_m_bytesel),
    .data_m_wr_en    (data_m_wr_en),
    .data_m_access   (data_m_access),
    .data_m_ack      (data_m_ack),
    .out             (out),
    .intr            (intr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Scoreboard: every ack pops one expected read word (writes expect 0).
  always @(negedge clk) begin
    if (reset_n) begin
      if (data_m_ack) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_ack", 32'(data_m_ack), 32'd0);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          check_eq("rdata", 32'(data_m_data_out), 32'(e));
        end
      end else begin
        check_eq("rdata_idle", 32'(data_m_data_out), 32'd0);
      end
    end
  end

  task automatic bus_acc(input logic wr, input logic [1:0] addr, input logic [1:0] bs,
                         input logic [15:0] wdata, input logic [15:0] exp);
    @(negedge clk);
    cs             = 1'b1;
    data_m_access  = 1'b1;
    data_m_wr_en   = wr;
    data_m_addr    = addr;
    data_m_bytesel = bs;
    data_m_data_in = wdata;
    exp_q.push_back(wr ? 16'h0000 : exp);
    @(negedge clk);
    cs            = 1'b0;
    data_m_access = 1'b0;
    data_m_wr_en  = 1'b0;
    check_eq("ack_hi", 32'(data_m_ack), 32'd1);
    @(negedge clk);
    check_eq("ack_lo", 32'(data_m_ack), 32'd0);
  endtask

  task automatic wr_ctrl(input logic [7:0] b);
    bus_acc(1'b1, 2'd1, 2'b10, {b, 8'h00}, 16'h0000);
  endtask

  task automatic wr_ch(input int ch, input logic [7:0] b);
    if (ch == 0)      bus_acc(1'b1, 2'd0, 2'b01, {8'h00, b}, 16'h0000);
    else if (ch == 1) bus_acc(1'b1, 2'd0, 2'b10, {b, 8'h00}, 16'h0000);
    else              bus_acc(1'b1, 2'd1, 2'b01, {8'h00, b}, 16'h0000);
  endtask

  task automatic rd_ch(input int ch, input logic [7:0] b);
    if (ch == 0)      bus_acc(1'b0, 2'd0, 2'b01, 16'h0000, {8'h00, b});
    else if (ch == 1) bus_acc(1'b0, 2'd0, 2'b10, 16'h0000, {b, 8'h00});
    else              bus_acc(1'b0, 2'd1, 2'b01, 16'h0000, {8'h00, b});
  endtask

  task automatic rd_cnt16(input int ch, input logic [15:0] v);
    rd_ch(ch, v[7:0]);
    rd_ch(ch, v[15:8]);
  endtask

  task automatic pit_tick();
    @(negedge clk);
    pit_clk = 1'b1;
    repeat (4) @(negedge clk);
    pit_clk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    reset_n        = 1'b0;
    pit_clk        = 1'b0;
    gate           = 3'b111;
    cs             = 1'b0;
    data_m_addr    = 2'd0;
    data_m_data_in = 16'h0000;
    data_m_bytesel = 2'b00;
    data_m_wr_en   = 1'b0;
    data_m_access  = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    check_eq("rst_out", 32'(out), 32'd0);
    check_eq("rst_intr", 32'(intr), 32'd0);
    check_eq("rst_ack", 32'(data_m_ack), 32'd0);
    bus_acc(1'b0, 2'd0, 2'b11, 16'h0000, 16'h0000);
    bus_acc(1'b0, 2'd1, 2'b01, 16'h0000, 16'h0000);
    wr_ctrl(8'hEE);  // read-back status of all three channels
    bus_acc(1'b0, 2'd0, 2'b11, 16'h0000, 16'h4040);
    bus_acc(1'b0, 2'd1, 2'b01, 16'h0000, 16'h0040);

    // ch0 mode 2, N=4
    wr_ctrl(8'h34);
    check_eq("m2_out_prog", 32'(out[0]), 32'd1);
    wr_ch(0, 8'h04);
    wr_ch(0, 8'h00);
    for (int k = 0; k < 12; k++) begin
      pit_tick();
      check_eq("m2_out", 32'(out[0]), (k % 4 == 3) ? 32'd0 : 32'd1);
      check_eq("m2_intr", 32'(intr), (k % 4 == 3) ? 32'd0 : 32'd1);
      rd_cnt16(0, (k % 4 == 0) ? 16'd4 : 16'(4 - (k % 4)));
    end

    // ch1 mode 3, N=5: high 3 ticks, low 2 ticks
    wr_ctrl(8'h76);
    wr_ch(1, 8'h05);
    wr_ch(1, 8'h00);
    for (int k = 0; k < 11; k++) begin
      pit_tick();
      check_eq("m3_out", 32'(out[1]), (k % 5 < 3) ? 32'd1 : 32'd0);
      rd_cnt16(1, (k % 5 == 0 || k % 5 == 3) ? 16'd4 : 16'd2);
    end
    wr_ctrl(8'hE4);
    rd_ch(1, 8'hB6);

    // ch2 mode 0, N=3
    wr_ctrl(8'hB0);
    wr_ch(2, 8'h03);
    check_eq("m0_out_first", 32'(out[2]), 32'd0);
    wr_ch(2, 8'h00);
    for (int k = 0; k < 6; k++) begin
      logic [15:0] ev;
      ev = 16'(3 - k);
      pit_tick();
      check_eq("m0_out", 32'(out[2]), (k >= 3) ? 32'd1 : 32'd0);
      rd_cnt16(2, ev);
    end
    wr_ctrl(8'hC8);  // read-back count + status of ch2
    rd_ch(2, 8'hB0);
    pit_tick();
    rd_cnt16(2, 16'hFFFE);
    rd_cnt16(2, 16'hFFFD);

    // ch0 counter latch at 0x1234
    wr_ctrl(8'h30);
    check_eq("m0_out_prog", 32'(out[0]), 32'd0);
    wr_ch(0, 8'h34);
    wr_ch(0, 8'h12);
    pit_tick();
    wr_ctrl(8'h00);
    repeat (2) pit_tick();
    wr_ctrl(8'h00);  // ignored, latch still full
    repeat (3) pit_tick();
    rd_ch(0, 8'h34);
    rd_ch(0, 8'h12);
    rd_cnt16(0, 16'h122F);
    wr_ctrl(8'h00);
    pit_tick();
    rd_cnt16(0, 16'h122F);
    rd_cnt16(0, 16'h122E);

    // Reset in the middle of a ch0 LSB/MSB write sequence
    wr_ctrl(8'h34);
    wr_ch(0, 8'h07);
    @(negedge clk);
    cs             = 1'b1;
    data_m_access  = 1'b1;
    data_m_wr_en   = 1'b1;
    data_m_addr    = 2'd0;
    data_m_bytesel = 2'b01;
    data_m_data_in = 16'h0000;
    #2 reset_n = 1'b0;
    @(negedge clk);
    check_eq("abort_ack", 32'(data_m_ack), 32'd0);
    cs            = 1'b0;
    data_m_access = 1'b0;
    data_m_wr_en  = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst2_out", 32'(out), 32'd0);
    check_eq("rst2_ack", 32'(data_m_ack), 32'd0);
    wr_ctrl(8'hE2);
    rd_ch(0, 8'h40);
    repeat (2) pit_tick();
    rd_ch(0, 8'h00);
    wr_ctrl(8'h34);
    wr_ch(0, 8'h06);
    wr_ch(0, 8'h00);
    pit_tick();
    rd_cnt16(0, 16'h0006);

    repeat (3) @(negedge clk);
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_channel_pit.md
Name: multi_channel_pit

Overview:
- Parametrised 8254-style programmable interval timer with up to three independent 16-bit channels.
- Each channel supports modes 0, 2 and 3, per-channel gates, counter-latch and read-back commands, and LSB/MSB/word access.
- Sits on the data bus next to the interrupt controller; channel 0 output drives the system tick interrupt.

Parameters:
NUM_CHANNELS, 3, number of implemented channels (1..3).
SYNC_STAGES, 2, flops in pit_clk and gate synchronisers (>=2).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
pit_clk  in  1  asynchronous counting clock (1.193182 MHz nominal)
gate  in  NUM_CHANNELS  per-channel gate, asynchronous
cs  in  1  block select
data_m_addr  in  [2:1]  word select
data_m_data_in  in  16  write data
data_m_data_out  out  16  read data
data_m_bytesel  in  2  byte lane enables
data_m_wr_en  in  1  write strobe
data_m_access  in  1  bus access
data_m_ack  out  1  access acknowledge
out  out  NUM_CHANNELS  channel outputs
intr  out  1  equals out[0]

Behaviour:
- Reset: reset_n low, asynchronous. All channels: mode 0, rw 00, bcd 0, count 0, reload 0, out 0, null_count 1, latches empty, byte flip-flop at LSB, channel idle (no counting until a count is written). Bus outputs data_m_data_out=0, data_m_ack=0, intr=0. Reset mid-access aborts the access; no ack is produced.
- Address map: word 0 lane0=ch0, lane1=ch1; word 1 lane0=ch2, lane1=control. Lane0 uses data[7:0], lane1 uses data[15:8]. Accesses to unimplemented channels read 0 and ignore writes. bytesel=11 serves both lanes in one access.
- Bus timing: data_m_ack is registered, asserted the cycle after cs&data_m_access. Read data appears in the same cycle as ack, in the addressed lane; unaddressed lanes are 0; data_m_data_out is 0 otherwise. Writes take effect on the access cycle.
- Tick: pit_clk is synchronised by SYNC_STAGES flops. A rising edge produces a one-clk tick shared by all channels. gate is synchronised the same way.
- Control write, ctrl[7:6]=channel:
  - rw=ctrl[5:4]=00 is the counter latch. If the count latch is empty, capture count; otherwise ignore.
  - Any other rw sets rw, mode=ctrl[3:1], bcd=ctrl[0]. It also sets null_count=1, resets the byte flip-flop and stops the channel. out becomes 0 for mode 0 and 1 for modes 2/3. Modes x10 and x11 alias to 2 and 3. Modes 1, 4 and 5 behave as mode 0. bcd is stored only; counting is binary.
- Read-back (ctrl[7:6]=11): ctrl[3:1] selects ch2..ch0.
  - ctrl[5]=0 latches the count and ctrl[4]=0 latches the status. Each latch is taken only if that latch is empty.
  - Status byte = {out, null_count, rw, mode, bcd}.
- Data write:
  - rw=01 writes the LSB and clears the MSB.
  - rw=10 writes the MSB and clears the LSB.
  - rw=11 takes the LSB then the MSB; the byte flip-flop toggles per write.
  - The final byte updates reload and sets null_count=1.
  - In mode 0, writing the first byte drives out low.
  - On the first tick after the final byte: count<=reload, null_count<=0, channel running.
- Data read precedence: status latch, then count latch bytes, then live count. Byte order follows rw (rw=11: LSB then MSB via flip-flop). Each latch empties once its bytes have been read.
- Counting: a running channel with gate=1 updates on each tick. Reload 0 means 65536.
  - Mode 0: decrement by 1. On the 1->0 transition out goes high and stays high until reprogrammed. The count wraps to FFFF and continues.
  - Mode 2: decrement by 1. When the count reaches 1, out is low for one tick period. The next tick reloads and drives out high, giving a period of N ticks. N=1 is illegal: out stays high and the channel reloads every tick.
  - Mode 3: the count loads N&~1 and decrements by 2. At terminal the channel toggles out and reloads. Even N: high N/2 ticks, low N/2 ticks. Odd N: high (N+1)/2 ticks, low (N-1)/2 ticks (one extra tick while high). Readback is always even.
  - gate=0: counting pauses; in modes 2/3 out is forced high. A gate rising edge in modes 2/3 reloads on the next tick.
- Simultaneous events:
  - Control write and tick in the same cycle: the write wins and the tick is dropped for that channel.
  - Latch and tick in the same cycle: the latch captures the pre-tick value.
  - Final data byte and tick in the same cycle: the tick acts on the old state.

Test Plan:
- Reset, then read ch0..ch2 and the status via read-back → counts 0, status 0x40, out=0, intr=0, ack exactly one cycle after each access.
- ch0 mode 2, rw=11, write 0x04,0x00, apply 12 ticks → out low for 1 tick of every 4; the read period is exactly 4.
- ch1 mode 3, N=5 → out high 3 ticks, low 2 ticks, repeating; readback values 4, 2 only.
- ch2 mode 0, N=3 → out low until the third tick after the load tick, then high; the count continues to FFFF, FFFE.
- ch0 counter latch mid-count at 0x1234, then 5 ticks, then two reads → 0x34, 0x12. A second latch before the reads is ignored. A live read afterwards shows the decremented value.
- Assert reset_n low during a ch0 rw=11 LSB/MSB write sequence → on release the channel is idle, null_count=1, and the next write is treated as the LSB.
